// File: rtl/sec_awe_pkg.sv
// Shared constants, H-matrix column table and FSM states
// for the 52-bit SEC encoder/decoder pair.
package sec_awe_pkg;

  localparam int DATA_W = 52;
  localparam int CHK_W  = 9;
  localparam int W_BITS = 61;

  typedef logic [DATA_W-1:0][CHK_W-1:0] col_tbl_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Data column i is the (i+1)-th 9-bit value of
  // weight >= 2, so every column differs from the
  // one-hot check columns and from each other.
  function automatic col_tbl_t gen_cols();
    col_tbl_t t;
    int n;
    logic [CHK_W-1:0] v;
    t = '0;
    n = 0;
    for (int k = 3; k < (1 << CHK_W); k++) begin
      v = k[CHK_W-1:0];
      if ($countones(v) >= 2 && n < DATA_W) begin
        t[n] = v;
        n++;
      end
    end
    return t;
  endfunction

  localparam col_tbl_t COL = gen_cols();

endpackage

// File: rtl/sec_chk_digit.sv
// Combinational partial check for one DIGIT-bit slice.
// digit_i: data slice, idx_i: slice index, part_o: XOR of columns.
module sec_chk_digit
  import sec_awe_pkg::*;
#(
  parameter int DIGIT = 4,
  parameter int IDX_W = 4
) (
  input  logic [DIGIT-1:0] digit_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [CHK_W-1:0] part_o
);

  int bi;

  always_comb begin
    part_o = '0;
    bi = 0;
    for (int j = 0; j < DIGIT; j++) begin
      bi = int'(idx_i) * DIGIT + j;
      if (digit_i[j] && bi < DATA_W) begin
        part_o = part_o ^ COL[bi];
      end
    end
  end

endmodule

// File: rtl/sec_encoder_awe_52bits_clk.sv
// Digit-serial SEC encoder: accepts a data word, folds DIGIT bits
// per clock into 9 check bits and presents {data, check} with an
// optional single-bit flip. Ports: clk, rst (sync, high),
// in_valid/in_ready/data_in/inj_en/inj_pos, out_valid/out_ready/W.
module sec_encoder_awe_52bits_clk #(
  parameter int DATA_W = sec_awe_pkg::DATA_W,
  parameter int CHK_W  = sec_awe_pkg::CHK_W,
  parameter int W_BITS = sec_awe_pkg::W_BITS,
  parameter int DIGIT  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic              inj_en,
  input  logic [5:0]        inj_pos,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W_BITS-1:0] W
);

  localparam int NDIG  = DATA_W / DIGIT;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

  if (W_BITS != DATA_W + CHK_W) begin : g_bad_w
    $error("W_BITS must equal DATA_W + CHK_W");
  end
  if (DATA_W % DIGIT != 0) begin : g_bad_digit
    $error("DIGIT must divide DATA_W");
  end

  sec_awe_pkg::state_e state_q, state_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CHK_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              inj_en_q, inj_en_d;
  logic [5:0]        inj_pos_q, inj_pos_d;
  logic [W_BITS-1:0] w_q, w_d;
  logic              out_valid_q, out_valid_d;

  logic [DIGIT-1:0]  digit;
  logic [CHK_W-1:0]  part;
  logic [CHK_W-1:0]  acc_nxt;
  logic [W_BITS-1:0] flip;

  assign digit = data_q[cnt_q*DIGIT +: DIGIT];

  sec_chk_digit #(
    .DIGIT (DIGIT),
    .IDX_W (CNT_W)
  ) u_dig (
    .digit_i (digit),
    .idx_i   (cnt_q),
    .part_o  (part)
  );

  assign acc_nxt = acc_q ^ part;

  // Out-of-range positions silently yield the clean word.
  always_comb begin
    flip = '0;
    if (inj_en_q && int'(inj_pos_q) < W_BITS) begin
      flip = W_BITS'(1) << inj_pos_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    data_d      = data_q;
    inj_en_d    = inj_en_q;
    inj_pos_d   = inj_pos_q;
    w_d         = w_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      sec_awe_pkg::ST_IDLE: begin
        if (in_valid) begin
          data_d    = data_in;
          inj_en_d  = inj_en;
          inj_pos_d = inj_pos;
          acc_d     = '0;
          cnt_d     = '0;
          state_d   = sec_awe_pkg::ST_ACCUM;
        end
      end
      sec_awe_pkg::ST_ACCUM: begin
        acc_d = acc_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          w_d         = {data_q, acc_nxt} ^ flip;
          out_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = sec_awe_pkg::ST_DONE;
        end
      end
      sec_awe_pkg::ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          w_d         = '0;
          state_d     = sec_awe_pkg::ST_IDLE;
        end
      end
      default: begin
        state_d = sec_awe_pkg::ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= sec_awe_pkg::ST_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      data_q      <= '0;
      inj_en_q    <= 1'b0;
      inj_pos_q   <= '0;
      w_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      data_q      <= data_d;
      inj_en_q    <= inj_en_d;
      inj_pos_q   <= inj_pos_d;
      w_q         <= w_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == sec_awe_pkg::ST_IDLE);
  assign out_valid = out_valid_q;
  assign W         = w_q;

endmodule

// File: tb/tb_sec_encoder_awe_52bits_clk.sv
// Directed bench for the digit-serial SEC encoder.
// Checks reset, latency, codewords, injection, hold and mid-word reset.
module tb_sec_encoder_awe_52bits_clk;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [51:0] data_in;
  logic        inj_en;
  logic [5:0]  inj_pos;
  logic        out_valid;
  logic        out_ready;
  logic [60:0] W;

  int checks;
  int errors;

  logic [8:0]  bcol [52];
  logic [60:0] w0;
  logic [60:0] wc;
  logic [60:0] ones_w;
  int          lat;

  sec_encoder_awe_52bits_clk dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .inj_en    (inj_en),
    .inj_pos   (inj_pos),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .W         (W)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [60:0] ref_w(input logic [51:0] d);
    logic [8:0] c;
    c = '0;
    for (int i = 0; i < 52; i++)
      if (d[i]) c = c ^ bcol[i];
    return {d, c};
  endfunction

  function automatic logic [8:0] syndrome(input logic [60:0] w);
    logic [8:0] s;
    s = w[8:0];
    for (int i = 0; i < 52; i++)
      if (w[9+i]) s = s ^ bcol[i];
    return s;
  endfunction

  // Offer a word, scramble inputs after accept, wait for out_valid.
  task automatic encode(input logic [51:0] d,
                        input logic ie,
                        input logic [5:0] ip,
                        output logic [60:0] w,
                        output int n);
    @(negedge clk);
    in_valid = 1'b1;
    data_in  = d;
    inj_en   = ie;
    inj_pos  = ip;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    data_in  = ~d;
    inj_en   = ~ie;
    inj_pos  = 6'd5;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    w = W;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int nv;
    logic [8:0] v;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    data_in   = '0;
    inj_en    = 1'b0;
    inj_pos   = '0;
    out_ready = 1'b0;

    nv = 0;
    for (int k = 1; k < 512; k++) begin
      v = k[8:0];
      if ($countones(v) >= 2 && nv < 52) begin
        bcol[nv] = v;
        nv++;
      end
    end

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_w", 64'(W), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    encode(52'd0, 1'b0, 6'd0, w0, lat);
    chk("zero_lat", 64'(lat), 64'd13);
    chk("zero_w", 64'(w0), 64'd0);
    chk("zero_in_ready", 64'(in_ready), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("zero_hold_valid", 64'(out_valid), 64'd1);
    consume();
    chk("zero_consumed", 64'(out_valid), 64'd0);
    chk("zero_idle", 64'(in_ready), 64'd1);

    encode(52'd1, 1'b0, 6'd0, w0, lat);
    chk("d1_lat", 64'(lat), 64'd13);
    chk("d1_w", 64'(w0), 64'd515);
    consume();
    chk("d1_w_cleared", 64'(W), 64'd0);

    encode(52'd2, 1'b0, 6'd0, w0, lat);
    chk("d2_w", 64'(w0), 64'd1029);
    consume();

    ones_w = ref_w({52{1'b1}});
    encode({52{1'b1}}, 1'b0, 6'd0, w0, lat);
    chk("ones_data", 64'(w0[60:9]), 64'h000F_FFFF_FFFF_FFFF);
    chk("ones_chk", 64'(w0[8:0]), 64'(ones_w[8:0]));
    chk("ones_syn", 64'(syndrome(w0)), 64'd0);
    consume();

    encode({52{1'b1}}, 1'b1, 6'd0, w0, lat);
    chk("inj0", 64'(w0 ^ ones_w), 64'd1);
    consume();
    encode({52{1'b1}}, 1'b1, 6'd9, w0, lat);
    chk("inj9", 64'(w0 ^ ones_w), 64'h200);
    chk("inj9_syn", 64'(syndrome(w0)), 64'd3);
    consume();
    encode({52{1'b1}}, 1'b1, 6'd60, w0, lat);
    chk("inj60", 64'(w0 ^ ones_w), 64'h1000_0000_0000_0000);
    consume();
    encode({52{1'b1}}, 1'b1, 6'd61, w0, lat);
    chk("inj61", 64'(w0), 64'(ones_w));
    consume();

    wc = ref_w(52'h1_2345_6789_ABCD);
    encode(52'h1_2345_6789_ABCD, 1'b0, 6'd0, w0, lat);
    chk("mix_lat", 64'(lat), 64'd13);
    chk("mix_w", 64'(w0), 64'(wc));
    in_valid = 1'b1;
    data_in  = 52'd2;
    inj_en   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("hold", {2'b0, W, in_ready}, {2'b0, wc, 1'b0});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("b2b_idle_valid", 64'(out_valid), 64'd0);
    chk("b2b_idle_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("b2b_accepted", 64'(in_ready), 64'd0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("b2b_lat", 64'(lat), 64'd13);
    chk("b2b_w", 64'(W), 64'd1029);
    consume();

    @(negedge clk);
    in_valid = 1'b1;
    data_in  = {52{1'b1}};
    inj_en   = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_w", 64'(W), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);

    encode(52'd1, 1'b0, 6'd0, w0, lat);
    chk("post_rst_lat", 64'(lat), 64'd13);
    chk("post_rst_w", 64'(w0), 64'd515);
    consume();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sec_encoder_awe_52bits_clk.md
Name: sec_encoder_awe_52bits_clk

Overview:
- Sequential SEC encoder that sits directly upstream of the 52-bit SEC decoder and produces its 61-bit codeword input W.
- Accepts a 52-bit data word over a valid/ready handshake and accumulates 9 check bits digit-serially, DIGIT data bits per clock.
- Presents the systematic codeword {data, check} with an optional single-bit error injection, so decoder benches and silicon tests get corrupted words from real hardware instead of files.

Parameters:
- DATA_W, 52, data bits per word.
- CHK_W, 9, check bits per word.
- W_BITS, 61, codeword width; must equal DATA_W+CHK_W (elaboration error otherwise).
- DIGIT, 4, data bits folded into the check per clock; must divide DATA_W (elaboration error otherwise).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  data word offered
- in_ready  out  1  encoder can accept a word
- data_in  in  DATA_W  data word, sampled on accept
- inj_en  in  1  flip one codeword bit; sampled on accept
- inj_pos  in  6  bit index to flip (0..60); sampled on accept
- out_valid  out  1  codeword W is valid
- out_ready  in  1  downstream consumes W
- W  out  W_BITS  codeword {data[51:0], check[8:0]}, with injection applied

Behaviour:
- Reset: on any rising edge with rst=1, state goes to IDLE, digit counter to 0, and the check accumulator, W, out_valid and the latched injection fields all clear. in_ready=1 on the first edge after rst deasserts. Reset mid-ACCUM or in DONE aborts the word and leaves no residue.
- H matrix:
  - Data bit i has 9-bit column COL[i], the (i+1)-th value of Hamming weight >=2 in ascending order (COL[0]=3, COL[1]=5, COL[2]=6, COL[3]=7, COL[4]=9, ...).
  - Check-bit column j is the one-hot value 1<<j.
  - check = XOR over i of (data[i] ? COL[i] : 0).
- FSM states: IDLE, ACCUM, DONE.
  - IDLE: in_ready=1. On in_valid=1: latch data_in, inj_en and inj_pos; clear accumulator; cnt=0; go to ACCUM.
  - ACCUM: in_ready=0. Each edge XORs the COL terms of data bits [cnt*DIGIT +: DIGIT] into the accumulator and increments cnt. On the edge processing digit DATA_W/DIGIT-1 (=12), load W and set out_valid=1 in the same edge, then go to DONE.
  - DONE: W and out_valid held stable. On out_ready=1: out_valid=0, go to IDLE.
- Latency: out_valid goes high on the 13th rising edge after the accepting edge (DATA_W/DIGIT edges in general).
- Throughput: one word per 15 clocks at best.
  - in_ready is high only in IDLE, so there is no accept while in DONE, even when out_ready=1 on the same edge.
  - in_valid in ACCUM/DONE is ignored and must be held by the source.
- Injection: if inj_en=1 and inj_pos<=60, W = clean ^ (1<<inj_pos). If inj_pos>=61, W = clean word, with no flip and no error indication.
- out_ready while out_valid=0 has no effect. W is 0 when out_valid=0.
- Sampled data_in, inj_en and inj_pos are immune to input changes after the accept edge.

Decomposition:
- Package sec_awe_pkg holds:
  - DATA_W, CHK_W and W_BITS constants.
  - The COL[0..51] column-constant table, or a function generating it, shared with the decoder so both sides use an identical H.
  - The FSM state enum.
- Sub-module sec_chk_digit: combinational DIGIT-bit to 9-bit partial-check XOR given the digit index. It is instantiated once, and the encoder holds all sequential state.

Test Plan:
- data_in=0, inj_en=0 -> W=0 exactly 13 edges after accept; out_valid held until out_ready.
- data_in=1 -> W=515 (data bit0, check 3); data_in=2 -> W=1029 (check 5).
- data_in=4503599627370495 (all ones), inj_en=0 -> W[60:9] all ones and W[8:0] = XOR of COL[0..51] from the package model; the downstream decoder returns N=4503599627370495 with found=1.
- Same data with inj_en=1 for inj_pos=0, 9, 60 -> W differs from the clean word in that single bit only. inj_pos=61 -> clean word.
- Hold out_ready=0 for 20 clocks after out_valid -> W stable and in_ready=0 throughout. Raise out_ready -> IDLE next edge, then a back-to-back second word is accepted.
- rst pulsed at ACCUM cnt=6 -> next edge has out_valid=0, W=0, in_ready=1. A fresh word then encodes correctly with no carry-over of accumulator contents.
